nco_sweep_ctrl: RTL and testbench
=================================

NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 SHALL have parameter FW, default 28, the frequency/phase control word width (matches NCO fre_chtr/pha_chtr).
REQ-002 SHALL have parameter DW, default 16, the dwell counter width.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins a sweep.
REQ-006 SHALL have port abort, input, 1, a one-cycle pulse that stops a sweep.
REQ-007 SHALL have ports cfg_f_start, cfg_f_stop and cfg_f_step, input, FW each, the sweep start, stop and step words.
REQ-008 SHALL have port cfg_dwell, input, DW, the step hold time in cycles minus 1.
REQ-009 SHALL have port cfg_pha, input, FW, the phase offset word.
REQ-010 SHALL have port cfg_repeat, input, 1, selecting continuous sweep (1) or single sweep (0).
REQ-011 SHALL have port cfg_tri, input, 1, selecting triangle sweep; used only under the configuration macro.
REQ-012 SHALL have ports fre_chtr and pha_chtr, output, FW each, registered, driving the NCO.
REQ-013 SHALL have port busy, output, 1, high while the FSM is not IDLE.
REQ-014 SHALL have port step_stb, output, 1, a one-cycle pulse whenever fre_chtr changes value.
REQ-015 SHALL have port done, output, 1, a one-cycle pulse at the end of a single sweep.

Function
REQ-016 FSM states SHALL be IDLE, UP, DOWN, DONE.
REQ-017 In IDLE, start SHALL latch all cfg_* into shadow registers; on the next edge fre_chtr = f_start, pha_chtr = cfg_pha, busy = 1, step_stb = 1, and the state becomes UP.
REQ-018 The cfg_* inputs SHALL be ignored while busy; a start while busy SHALL be ignored.
REQ-019 Each frequency SHALL be held cfg_dwell+1 cycles; cfg_dwell = 0 gives one cycle per step.
REQ-020 At the end of a dwell in UP, next = fre_chtr + f_step SHALL be computed FW+1 bits wide; if next <= f_stop and there is no carry, fre_chtr <= next and step_stb pulses.
REQ-021 At the end of a dwell in UP when the step would overshoot (next > f_stop or carry):
 - repeat=1, tri=0: fre_chtr <= f_start, step_stb pulses, stay in UP.
 - repeat=0, tri=0: go to DONE.
 - tri=1: go to DOWN.
REQ-022 DOWN SHALL subtract f_step per dwell down to f_start, with the borrow checked. On underflow: repeat=1 gives UP; repeat=0 gives DONE.
REQ-023 DONE SHALL pulse done for one cycle, then go to IDLE; fre_chtr and pha_chtr keep their last values.
REQ-024 f_step = 0 SHALL hold f_start indefinitely; no done is produced; only abort exits.
REQ-025 f_start > f_stop SHALL give one dwell at f_start, then DONE, or a restart when repeat=1.
REQ-026 abort SHALL force IDLE on the next edge, with no done pulse and fre_chtr/pha_chtr held; abort has priority over a dwell-end in the same cycle.
REQ-027 start and abort asserted together in IDLE: abort SHALL win and the state stays IDLE.
REQ-028 All arithmetic SHALL be unsigned; fre_chtr SHALL never wrap modulo 2^FW.

Reset
REQ-029 rst_n low SHALL asynchronously clear the state to IDLE and clear fre_chtr, pha_chtr, busy, step_stb, done, the dwell counter and the shadow registers to 0.
REQ-030 A reset mid-sweep SHALL have no retained context; the block restarts only on a new start.

Configuration
REQ-031 Macro NCO_SWEEP_TRIANGLE_EN defined: the DOWN state and cfg_tri SHALL be functional.
REQ-032 Macro NCO_SWEEP_TRIANGLE_EN undefined: DOWN SHALL not be synthesized, cfg_tri is ignored (treated as 0), and behaviour is sawtooth only.

Structure
REQ-033 Shared package nco_pkg SHALL hold the FW/DW defaults, the FSM state encoding, and the constant PHASE_90 = 28'd67108864.
REQ-034 The dwell counter SHALL be a sub-module nco_dwell_cnt (load, enable, terminal-count output); everything else stays in the top module.

Verification
REQ-035 start, f_start=100, f_stop=400, f_step=100, dwell=2, repeat=0 -> fre_chtr 100,200,300,400 for 3 cycles each, then one done pulse, busy=0, fre_chtr stays 400.
REQ-036 Same settings with repeat=1 -> after 400 comes 100 again, and step_stb pulses every 3 cycles with no done.
REQ-037 f_start=0x FFFFF00, f_step=0x200, f_stop=0xFFFFFFF -> the carry is detected, there is no wrap to 0x0000100, and done follows.
REQ-038 With NCO_SWEEP_TRIANGLE_EN, tri=1, 100..300 step 100, dwell=0, repeat=1 -> fre_chtr sequence 100,200,300,200,100,200...
REQ-039 abort on the same cycle as a dwell-end at 200 -> next cycle IDLE, fre_chtr=200, no step_stb, no done.
REQ-040 rst_n low mid-sweep, asynchronously (not on a clock edge) -> all outputs 0 immediately; start after release restarts from cfg_f_start.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared definitions for the NCO sweep controller: width defaults, FSM state
// encoding and the quarter-turn phase constant for a 28-bit phase accumulator.
package nco_pkg;

  localparam int FW_DEFAULT = 28;
  localparam int DW_DEFAULT = 16;

  // 2^26: a 90 degree offset for a 28-bit phase word.
  localparam logic [27:0] PHASE_90 = 28'd67108864;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/nco_dwell_cnt.sv
// Dwell counter: loads a hold time, counts down to zero and flags the
// terminal count. The last cycle of a dwell is the cycle where tc_o is high.
module nco_dwell_cnt #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          en_i,
  input  logic [DW-1:0] load_val_i,
  output logic          tc_o
);

  logic [DW-1:0] cnt_q;

  // Down-counter; load wins over decrement.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i) begin
      cnt_q <= cnt_q - DW'(1);
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency sweep controller driving an NCO's frequency and phase words.
// Sawtooth sweep by default; define NCO_SWEEP_TRIANGLE_EN to add the DOWN
// state and make cfg_tri select a triangle sweep.
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int FW = FW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [FW-1:0] cfg_f_start,
  input  logic [FW-1:0] cfg_f_stop,
  input  logic [FW-1:0] cfg_f_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [FW-1:0] cfg_pha,
  input  logic          cfg_repeat,
  input  logic          cfg_tri,
  output logic [FW-1:0] fre_chtr,
  output logic [FW-1:0] pha_chtr,
  output logic          busy,
  output logic          step_stb,
  output logic          done
);

  state_e        state_q;
  logic [FW-1:0] fre_q, pha_q;
  logic [FW-1:0] f_start_q, f_stop_q, f_step_q;
  logic [DW-1:0] dwell_q;
  logic          repeat_q;
  logic          busy_q, stb_q, done_q;

  logic [FW:0]   up_sum, dn_diff;
  logic          up_over, dn_under, turn_down;
  logic          sweeping, dwell_tc, dwell_end, start_ok;
  logic [DW-1:0] dwell_load_val;

  // One extra bit exposes carry/borrow so the word never wraps.
  assign up_sum   = {1'b0, fre_q} + {1'b0, f_step_q};
  assign up_over  = up_sum[FW] || (up_sum[FW-1:0] > f_stop_q);
  assign dn_diff  = {1'b0, fre_q} - {1'b0, f_step_q};
  assign dn_under = dn_diff[FW] || (dn_diff[FW-1:0] < f_start_q);

`ifdef NCO_SWEEP_TRIANGLE_EN
  logic tri_q;
  assign turn_down = tri_q;
`else
  // Sawtooth-only build: the triangle select is deliberately ignored.
  logic unused_tri;
  assign unused_tri = cfg_tri;
  assign turn_down  = 1'b0;
`endif

  assign sweeping       = (state_q == ST_UP) || (state_q == ST_DOWN);
  assign dwell_end      = sweeping && dwell_tc;
  assign start_ok       = (state_q == ST_IDLE) && start && !abort;
  assign dwell_load_val = (state_q == ST_IDLE) ? cfg_dwell : dwell_q;

  nco_dwell_cnt #(.DW(DW)) u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (start_ok || dwell_end),
    .en_i       (sweeping && !dwell_tc),
    .load_val_i (dwell_load_val),
    .tc_o       (dwell_tc)
  );

  // Sweep FSM with registered outputs; abort overrides every transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shadow config is ordinary flops, so it is cleared by reset like all other state.
      state_q   <= ST_IDLE;
      fre_q     <= '0;
      pha_q     <= '0;
      f_start_q <= '0;
      f_stop_q  <= '0;
      f_step_q  <= '0;
      dwell_q   <= '0;
      repeat_q  <= 1'b0;
`ifdef NCO_SWEEP_TRIANGLE_EN
      tri_q     <= 1'b0;
`endif
      busy_q    <= 1'b0;
      stb_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      stb_q  <= 1'b0;
      done_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              f_start_q <= cfg_f_start;
              f_stop_q  <= cfg_f_stop;
              f_step_q  <= cfg_f_step;
              dwell_q   <= cfg_dwell;
              repeat_q  <= cfg_repeat;
`ifdef NCO_SWEEP_TRIANGLE_EN
              tri_q     <= cfg_tri;
`endif
              fre_q     <= cfg_f_start;
              pha_q     <= cfg_pha;
              busy_q    <= 1'b1;
              stb_q     <= 1'b1;
              state_q   <= ST_UP;
            end
          end
          ST_UP: begin
            // A zero step parks on f_start until aborted.
            if (dwell_end && (f_step_q != '0)) begin
              if (!up_over) begin
                fre_q <= up_sum[FW-1:0];
                stb_q <= 1'b1;
              end else if (turn_down) begin
                // Turn at the top without repeating the top frequency.
                state_q <= ST_DOWN;
                if (!dn_under) begin
                  fre_q <= dn_diff[FW-1:0];
                  stb_q <= 1'b1;
                end
              end else if (repeat_q) begin
                fre_q <= f_start_q;
                stb_q <= 1'b1;
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end
          end
`ifdef NCO_SWEEP_TRIANGLE_EN
          ST_DOWN: begin
            if (dwell_end) begin
              if (!dn_under) begin
                fre_q <= dn_diff[FW-1:0];
                stb_q <= 1'b1;
              end else if (repeat_q) begin
                // Turn at the bottom without repeating f_start.
                state_q <= ST_UP;
                if (!up_over) begin
                  fre_q <= up_sum[FW-1:0];
                  stb_q <= 1'b1;
                end
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end
          end
`endif
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fre_chtr = fre_q;
  assign pha_chtr = pha_q;
  assign busy     = busy_q;
  assign step_stb = stb_q;
  assign done     = done_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl: a slot-level sweep model predicts every
// step_stb/done pulse (value and cycle); a monitor pops and compares them.
module tb_nco_sweep_ctrl;

  localparam int     FW   = 28;
  localparam int     DW   = 16;
  localparam longint MAXV = (longint'(1) << FW) - 1;
`ifdef NCO_SWEEP_TRIANGLE_EN
  localparam bit TRI_EN = 1'b1;
`else
  localparam bit TRI_EN = 1'b0;
`endif

  typedef struct {
    logic [FW-1:0] f_start, f_stop, f_step;
    logic [DW-1:0] dwell;
    logic [FW-1:0] pha;
    bit            rpt, tri_m;
  } cfg_t;

  typedef struct { longint val; bit stb; } slot_t;
  typedef struct { bit is_done; longint fre; int cyc; } exp_t;

  logic          clk, rst_n, start, abort, cfg_repeat, cfg_tri;
  logic [FW-1:0] cfg_f_start, cfg_f_stop, cfg_f_step, cfg_pha;
  logic [DW-1:0] cfg_dwell;
  logic [FW-1:0] fre_chtr, pha_chtr;
  logic          busy, step_stb, done;

  int     n_cmp = 0;
  int     n_err = 0;
  int     cyc   = 0;
  longint model_fre = 0;
  slot_t  slots[$];
  bit     slots_end;
  exp_t   exp_q[$];
  exp_t   mon_e;

  nco_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .cfg_f_start (cfg_f_start),
    .cfg_f_stop  (cfg_f_stop),
    .cfg_f_step  (cfg_f_step),
    .cfg_dwell   (cfg_dwell),
    .cfg_pha     (cfg_pha),
    .cfg_repeat  (cfg_repeat),
    .cfg_tri     (cfg_tri),
    .fre_chtr    (fre_chtr),
    .pha_chtr    (pha_chtr),
    .busy        (busy),
    .step_stb    (step_stb),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the list of dwell slots a sweep visits, each tagged with
  // whether the frequency word is (re)written at the start of that slot.
  function automatic void build_slots(input cfg_t c, input int max_slots);
    longint st, sp, stp;
    int     n;
    slots.delete();
    slots_end = 1'b0;
    st = longint'(c.f_start); sp = longint'(c.f_stop); stp = longint'(c.f_step);
    if (stp == 0) begin
      for (int k = 0; k < max_slots; k++) slots.push_back('{st, k == 0});
      return;
    end
    n = (st > sp) ? 1 : int'((sp - st) / stp) + 1;
    if (!(TRI_EN && c.tri_m)) begin
      if (!c.rpt) begin
        for (int i = 0; i < n; i++) slots.push_back('{st + i * stp, 1'b1});
        slots_end = 1'b1;
      end else begin
        for (int k = 0; k < max_slots; k++) slots.push_back('{st + (k % n) * stp, 1'b1});
      end
    end else if (n == 1) begin
      // No room to move either way: the frequency just sits at f_start.
      for (int k = 0; k < (c.rpt ? max_slots : 2); k++) slots.push_back('{st, k == 0});
      slots_end = !c.rpt;
    end else begin
      for (int i = 0; i < n; i++) slots.push_back('{st + i * stp, 1'b1});
      for (int i = n - 2; i >= 0; i--) slots.push_back('{st + i * stp, 1'b1});
      if (c.rpt) begin
        while (slots.size() < max_slots) begin
          for (int i = 1; i < n; i++) slots.push_back('{st + i * stp, 1'b1});
          for (int i = n - 2; i >= 0; i--) slots.push_back('{st + i * stp, 1'b1});
        end
      end
      slots_end = !c.rpt;
    end
  endfunction

  task automatic drive_cfg(input cfg_t c);
    cfg_f_start = c.f_start; cfg_f_stop = c.f_stop; cfg_f_step = c.f_step;
    cfg_dwell = c.dwell; cfg_pha = c.pha; cfg_repeat = c.rpt; cfg_tri = c.tri_m;
  endtask

  task automatic scramble_cfg();
    cfg_f_start = FW'($urandom()); cfg_f_stop = FW'($urandom());
    cfg_f_step = FW'($urandom()); cfg_dwell = DW'($urandom());
    cfg_pha = FW'($urandom()); cfg_repeat = 1'($urandom()); cfg_tri = 1'($urandom());
  endtask

  function automatic cfg_t mk(input longint a, input longint b, input longint s,
                              input int dw, input bit rpt, input bit tm);
    cfg_t c;
    c.f_start = FW'(a); c.f_stop = FW'(b); c.f_step = FW'(s);
    c.dwell = DW'(dw); c.pha = FW'($urandom()); c.rpt = rpt; c.tri_m = tm;
    return c;
  endfunction

  function automatic cfg_t rand_cfg(input bit rpt);
    cfg_t   c;
    longint span, stop;
    int     n, mode;
    c.f_step  = FW'($urandom_range(1, 5000));
    c.f_start = FW'($urandom());
    n = $urandom_range(1, 6);
    span = longint'(n - 1) * longint'(c.f_step) + longint'($urandom_range(0, int'(c.f_step) - 1));
    stop = longint'(c.f_start) + span;
    c.f_stop = FW'((stop > MAXV) ? MAXV : stop);
    mode = $urandom_range(0, 7);
    if (mode == 0 && c.f_start != '0) c.f_stop = c.f_start - FW'(1);
    if (mode == 1 && rpt) c.f_step = '0;
    if (mode == 2) begin
      c.f_start = FW'(MAXV - longint'($urandom_range(0, 3000)));
      c.f_stop  = FW'(MAXV);
    end
    c.dwell = DW'($urandom_range(0, 3));
    c.pha   = FW'($urandom());
    c.rpt   = rpt;
    c.tri_m = 1'($urandom_range(0, 1));
    return c;
  endfunction

  // Issue one sweep, push its predicted pulses, optionally abort after
  // abort_after cycles, and optionally poke a start while busy.
  task automatic run_sweep(input cfg_t c, input int abort_after, input bit poke);
    int c0, d, ca, nmax, idx, end_c;
    @(negedge clk);
    drive_cfg(c);
    start = 1'b1;
    c0   = cyc + 1;
    d    = int'(c.dwell) + 1;
    ca   = (abort_after > 0) ? c0 + abort_after : 32'h7fff_ffff;
    nmax = (abort_after > 0) ? abort_after / d + 2 : 0;
    build_slots(c, nmax);
    for (int k = 0; k < slots.size(); k++)
      if (slots[k].stb && (c0 + k * d < ca)) exp_q.push_back('{1'b0, slots[k].val, c0 + k * d});
    if (slots_end && (c0 + slots.size() * d < ca))
      exp_q.push_back('{1'b1, slots[slots.size() - 1].val, c0 + slots.size() * d});
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble_cfg();
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("pha_after_start", pha_chtr, c.pha);
    if (poke) begin
      @(negedge clk); @(negedge clk);
      start = 1'b1; scramble_cfg();
      @(negedge clk);
      start = 1'b0;
    end
    if (abort_after > 0) begin
      while (cyc < ca - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      idx = (ca - 1 - c0) / d;
      if (idx >= slots.size()) idx = slots.size() - 1;
      model_fre = slots[idx].val;
      check("abort_busy", busy, 0);
      check("abort_fre", fre_chtr, model_fre);
      check("abort_stb", step_stb, 0);
      check("abort_done", done, 0);
    end else begin
      end_c = c0 + slots.size() * d + 1;
      while (cyc < end_c) @(negedge clk);
      model_fre = slots[slots.size() - 1].val;
      check("end_busy", busy, 0);
      check("end_fre", fre_chtr, model_fre);
    end
    repeat (3) @(negedge clk);
    check("hold_fre", fre_chtr, model_fre);
    check("evt_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: every pulse must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (rst_n && (step_stb || done)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_evt", longint'(step_stb | done), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("evt_done", done, mon_e.is_done);
        check("evt_stb", step_stb, !mon_e.is_done);
        check("evt_fre", fre_chtr, mon_e.fre);
        check("evt_cyc", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_t c;
    bit   rpt;
    int   c0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_f_start = '0; cfg_f_stop = '0; cfg_f_step = '0;
    cfg_dwell = '0; cfg_pha = '0; cfg_repeat = 1'b0; cfg_tri = 1'b0;
    #2;
    check("rst_fre", fre_chtr, 0);
    check("rst_pha", pha_chtr, 0);
    check("rst_busy", busy, 0);
    check("rst_stb", step_stb, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single sweep 100..400, 3 cycles per step, then done.
    run_sweep(mk(100, 400, 100, 2, 0, 0), 0, 0);
    // Continuous sweep with a start poked while busy.
    run_sweep(mk(100, 400, 100, 2, 1, 0), 30, 1);
    // Step would carry out of FW bits: no wrap, done follows.
    run_sweep(mk(28'hFFFFF00, 28'hFFFFFFF, 28'h200, 1, 0, 0), 0, 0);
    // Triangle select (sawtooth when the feature is compiled out).
    run_sweep(mk(100, 300, 100, 0, 1, 1), 12, 0);
    run_sweep(mk(100, 300, 100, 1, 0, 1), 0, 0);
    // Abort on the dwell-end edge leaving 200.
    run_sweep(mk(100, 400, 100, 2, 0, 0), 6, 0);

    // start and abort together in IDLE: nothing happens.
    @(negedge clk);
    drive_cfg(mk(7, 70, 7, 0, 0, 0));
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_fre", fre_chtr, model_fre);

    // Zero step holds f_start; only abort leaves.
    run_sweep(mk(555, 900, 0, 1, 0, 0), 15, 0);
    // f_start above f_stop: one dwell, then done or restart.
    run_sweep(mk(500, 400, 10, 1, 0, 0), 0, 0);
    run_sweep(mk(500, 400, 10, 1, 1, 0), 10, 0);

    for (int it = 0; it < 24; it++) begin
      rpt = 1'($urandom_range(0, 1));
      c = rand_cfg(rpt);
      run_sweep(c, rpt ? $urandom_range(5, 40) : 0, rpt && ($urandom_range(0, 1) == 1));
    end

    // Asynchronous reset mid-sweep, then a fresh start.
    c = mk(100, 400, 100, 1, 1, 0);
    @(negedge clk);
    drive_cfg(c);
    start = 1'b1;
    c0 = cyc + 1;
    build_slots(c, 10);
    for (int k = 0; k < slots.size(); k++)
      if (c0 + k * 2 <= c0 + 5) exp_q.push_back('{1'b0, slots[k].val, c0 + k * 2});
    @(posedge clk);
    #1;
    start = 1'b0;
    while (cyc < c0 + 5) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_fre", fre_chtr, 0);
    check("arst_pha", pha_chtr, 0);
    check("arst_busy", busy, 0);
    check("arst_stb", step_stb, 0);
    check("arst_done", done, 0);
    check("arst_drain", exp_q.size(), 0);
    exp_q.delete();
    model_fre = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(mk(2000, 2600, 300, 0, 0, 0), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
